bsg_locking_arb_rr: RTL

Parametrised locking arbiter with selectable fixed or round-robin priority. It grants one of inputs_p requesters, then holds that grant for the whole multi-cycle transaction until unlock_i. Other requesters are ignored while locked. It sits in front of shared single-owner resources (NoC links, memory ports), where a burst must not be interleaved.

---
 rtl/bsg_locking_arb_pkg.sv | 14 +
 rtl/bsg_rr_pick_one_hot.sv | 32 +++
 rtl/bsg_locking_arb_rr.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bsg_locking_arb_pkg.sv
// Shared types and helpers for the locking round-robin arbiter.
package bsg_locking_arb_pkg;

  typedef enum logic {
    e_arb_idle   = 1'b0,
    e_arb_locked = 1'b1
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned lg_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_rr_pick_one_hot.sv
// Rotating-priority pick: first set request scanning upward from last_i+1, with wrap.
module bsg_rr_pick_one_hot
  import bsg_locking_arb_pkg::*;
#(
  parameter int unsigned width_p = 16,
  localparam int unsigned lg_width_lp = lg_width(width_p)
) (
  input  logic [width_p-1:0]     reqs_i,
  input  logic [lg_width_lp-1:0] last_i,
  output logic [width_p-1:0]     one_hot_o,
  output logic                   v_o
);

  int unsigned idx;
  logic        found;

  always_comb begin
    one_hot_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= width_p; k++) begin
      idx = (32'(last_i) + k) % width_p;
      if (!found && reqs_i[lg_width_lp'(idx)]) begin
        one_hot_o[lg_width_lp'(idx)] = 1'b1;
        found                        = 1'b1;
      end
    end
  end

  assign v_o = |reqs_i;

endmodule

// File: rtl/bsg_locking_arb_rr.sv
// Locking arbiter: grants one requester and holds it until unlock.
// Optional lock timeout enabled by defining BSG_LOCKING_ARB_RR_TIMEOUT_EN.
module bsg_locking_arb_rr
  import bsg_locking_arb_pkg::*;
#(
  parameter int unsigned inputs_p          = 16,
  parameter int unsigned rr_p              = 1,
  parameter int unsigned max_lock_cycles_p = 64,
  localparam int unsigned lg_inputs_lp     = lg_width(inputs_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [inputs_p-1:0]     reqs_i,
  input  logic                    ready_i,
  input  logic                    unlock_i,
  output logic [inputs_p-1:0]     grants_o,
  output logic                    locked_o,
  output logic [lg_inputs_lp-1:0] owner_id_o,
  output logic                    timeout_o
);

  arb_state_e              state_r;
  logic [lg_inputs_lp-1:0] owner_r;
  logic [lg_inputs_lp-1:0] last_r;
  logic [lg_inputs_lp-1:0] pick_last;
  logic [lg_inputs_lp-1:0] winner;
  logic [inputs_p-1:0]     pick_oh;
  logic [inputs_p-1:0]     owner_oh;
  logic                    pick_v;
  logic                    idle_grant;
  logic                    release_lock;
  logic                    expire;

  if (inputs_p < 1) begin : g_bad_inputs
    $error("bsg_locking_arb_rr: inputs_p must be >= 1");
  end
  if (max_lock_cycles_p < 2) begin : g_bad_timeout
    $error("bsg_locking_arb_rr: max_lock_cycles_p must be >= 2");
  end

  // Fixed priority reuses the rotating picker with the pointer pinned so bit 0 wins.
  assign pick_last = (rr_p != 0) ? last_r : lg_inputs_lp'(inputs_p - 1);

  bsg_rr_pick_one_hot #(
    .width_p(inputs_p)
  ) pick (
    .reqs_i   (reqs_i),
    .last_i   (pick_last),
    .one_hot_o(pick_oh),
    .v_o      (pick_v)
  );

  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < inputs_p; i++) begin
      if (pick_oh[i]) winner = lg_inputs_lp'(i);
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int unsigned i = 0; i < inputs_p; i++) begin
      owner_oh[i] = (owner_r == lg_inputs_lp'(i));
    end
  end

  // Grant depends only on state, requests and ready; unlock_i never reaches it.
  always_comb begin
    grants_o = '0;
    if (!reset_i) begin
      if (state_r == e_arb_idle) grants_o = pick_oh & {inputs_p{ready_i}};
      else                       grants_o = owner_oh & reqs_i & {inputs_p{ready_i}};
    end
  end

  assign idle_grant = (state_r == e_arb_idle) && pick_v && ready_i;

`ifdef BSG_LOCKING_ARB_RR_TIMEOUT_EN
  localparam int unsigned cnt_width_lp = $clog2(max_lock_cycles_p);

  logic [cnt_width_lp-1:0] lock_cnt_r;

  // Held at zero outside LOCKED so the first locked cycle counts from zero.
  always_ff @(posedge clk_i) begin
    if (reset_i || state_r != e_arb_locked) lock_cnt_r <= '0;
    else                                    lock_cnt_r <= lock_cnt_r + cnt_width_lp'(1);
  end

  assign expire = (state_r == e_arb_locked) && !unlock_i
               && (lock_cnt_r == cnt_width_lp'(max_lock_cycles_p - 1));
`else
  assign expire = 1'b0;
`endif

  assign timeout_o    = expire && !reset_i;
  assign release_lock = (state_r == e_arb_locked) && (unlock_i || expire);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_arb_idle;
      owner_r <= '0;
      last_r  <= lg_inputs_lp'(inputs_p - 1);
    end else begin
      case (state_r)
        e_arb_idle: begin
          if (idle_grant) begin
            owner_r <= winner;
            if (unlock_i) begin
              if (rr_p != 0) last_r <= winner;
            end else begin
              state_r <= e_arb_locked;
            end
          end
        end
        e_arb_locked: begin
          if (release_lock) begin
            state_r <= e_arb_idle;
            if (rr_p != 0) last_r <= owner_r;
          end
        end
        default: state_r <= e_arb_idle;
      endcase
    end
  end

  assign locked_o   = (state_r == e_arb_locked);
  assign owner_id_o = owner_r;

endmodule
